// File: rtl/fs_host_sequencer_pkg.sv
// Shared definitions for the feature-selection host sequencer: slave register
// map, CTRL word layout, axis codes, FSM state encoding and the bus request type.
package fs_host_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  // Slave register addresses
  localparam logic [ADDR_W-1:0] A_RF    = 3'd0;
  localparam logic [ADDR_W-1:0] A_CT    = 3'd1;
  localparam logic [ADDR_W-1:0] A_CTRL  = 3'd2;
  localparam logic [ADDR_W-1:0] A_DOUT  = 3'd3;
  localparam logic [ADDR_W-1:0] A_RFCNT = 3'd4;
  localparam logic [ADDR_W-1:0] A_CTCNT = 3'd5;
  localparam logic [ADDR_W-1:0] A_FCL   = 3'd6;
  localparam logic [ADDR_W-1:0] A_FCH   = 3'd7;

  // CTRL word bit positions
  localparam int CTRL_START_BIT = 15;
  localparam int CTRL_INTEN_BIT = 2;

  // Axis selector codes (CTRL[1:0])
  localparam logic [1:0] AXIS_X = 2'b00;
  localparam logic [1:0] AXIS_Y = 2'b01;
  localparam logic [1:0] AXIS_Z = 2'b10;

  // Sequencer FSM encoding
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_FCL   = 4'd1;
  localparam logic [3:0] ST_WR_FCH   = 4'd2;
  localparam logic [3:0] ST_WR_CTRL  = 4'd3;
  localparam logic [3:0] ST_LD_CENT  = 4'd4;
  localparam logic [3:0] ST_LD_RF    = 4'd5;
  localparam logic [3:0] ST_WAIT_INT = 4'd6;
  localparam logic [3:0] ST_RD_DOUT  = 4'd7;
  localparam logic [3:0] ST_CLR      = 4'd8;

  // One register-bus transaction request; rw=1 is a write
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Assemble a CTRL register value from its fields
  function automatic logic [DATA_W-1:0] ctrl_word(input logic start,
                                                  input logic int_en,
                                                  input logic [1:0] axis);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CTRL_START_BIT] = start;
    w[CTRL_INTEN_BIT] = int_en;
    w[1:0] = axis;
    return w;
  endfunction

endpackage

// File: rtl/fs_host_sequencer_if.sv
// Register bus between the host sequencer (master) and the classifier (slave):
// 3-bit address, 16-bit data, active-low strobes, combinational read data and
// a level interrupt from the slave.
interface fs_host_sequencer_if;
  import fs_host_sequencer_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              nCs;
  logic              nWr;
  logic              nRd;
  logic [DATA_W-1:0] rdata;
  logic              intr;

  modport master (
    output addr, wdata, nCs, nWr, nRd,
    input  rdata, intr
  );

  modport slave (
    input  addr, wdata, nCs, nWr, nRd,
    output rdata, intr
  );

endinterface

// File: rtl/fs_bus_slot.sv
// Single register-bus transaction engine. A request accepted while free opens
// one strobe cycle (write or read); the following cycle deasserts the strobes
// and reports done, and is already free to accept the next request, so
// back-to-back writes take two clocks each. Addr/wdata stay registered through
// the gap. Only the low RD_W bits of read data are kept.
module fs_bus_slot
  import fs_host_sequencer_pkg::*;
#(
  parameter int RD_W = 2
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              req,
  input  bus_req_t          req_data,
  input  logic [RD_W-1:0]   rdata,
  output logic              free,
  output logic              done,
  output logic [RD_W-1:0]   rd_q,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              nCs,
  output logic              nWr,
  output logic              nRd
);

  logic active;
  logic rw_q;

  assign free = !active;

  // Strobe cycle on request, idle gap plus done pulse on the cycle after
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      active <= 1'b0;
      rw_q   <= 1'b1;
      done   <= 1'b0;
      rd_q   <= '0;
      addr   <= '0;
      wdata  <= '0;
      nCs    <= 1'b1;
      nWr    <= 1'b1;
      nRd    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (active) begin
        active <= 1'b0;
        nCs    <= 1'b1;
        nWr    <= 1'b1;
        nRd    <= 1'b1;
        done   <= 1'b1;
        if (!rw_q) begin
          rd_q <= rdata;
        end
      end else if (req) begin
        active <= 1'b1;
        rw_q   <= req_data.rw;
        addr   <= req_data.addr;
        wdata  <= req_data.wdata;
        nCs    <= 1'b0;
        nWr    <= !req_data.rw;
        nRd    <= req_data.rw;
      end
    end
  end

endmodule

// File: rtl/fs_host_sequencer.sv
// Host-side sequencer for the feature-selection classifier. Per batch it
// programs the feature code, then for each axis x/y/z writes CTRL and streams
// centroid words into CT and raw samples into RF, waits for the interrupt,
// reads the group from DOUT and finally clears CTRL. Bus timing lives in
// fs_bus_slot; this module only decides which request to issue.
module fs_host_sequencer
  import fs_host_sequencer_pkg::*;
#(
  parameter int CENT_PER_AXIS    = 10,
  parameter int SAMPLES_PER_AXIS = 256,
  parameter int TIMEOUT          = 65535
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 go,
  input  logic [29:0]          feature_code,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  fs_host_sequencer_if.master  bus,
  output logic                 busy,
  output logic                 group_valid,
  output logic [1:0]           group,
  output logic                 timeout
);

  localparam logic [15:0] CENT_LAST = 16'(CENT_PER_AXIS - 1);
  localparam logic [15:0] SAMP_LAST = 16'(SAMPLES_PER_AXIS - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  logic [3:0]  state;
  logic [29:0] code_q;
  logic [1:0]  axis;
  logic [15:0] wcnt;
  logic [15:0] tcnt;
  logic        rd_pend;

  logic        slot_req;
  bus_req_t    slot_rq;
  logic        slot_free;
  logic        slot_done;
  logic [1:0]  slot_rd;
  logic        accept;

  assign accept = in_valid && in_ready;

  // Request selection and stream handshake for the current state
  always_comb begin
    slot_req       = 1'b0;
    slot_rq.rw     = 1'b1;
    slot_rq.addr   = A_RF;
    slot_rq.wdata  = '0;
    in_ready       = 1'b0;
    case (state)
      ST_WR_FCL: begin
        slot_req      = slot_free;
        slot_rq.addr  = A_FCL;
        slot_rq.wdata = code_q[15:0];
      end
      ST_WR_FCH: begin
        slot_req      = slot_free;
        slot_rq.addr  = A_FCH;
        slot_rq.wdata = {2'b00, code_q[29:16]};
      end
      ST_WR_CTRL: begin
        slot_req      = slot_free;
        slot_rq.addr  = A_CTRL;
        slot_rq.wdata = ctrl_word(1'b1, 1'b1, axis);
      end
      ST_LD_CENT: begin
        in_ready      = slot_free;
        slot_req      = slot_free && in_valid;
        slot_rq.addr  = A_CT;
        slot_rq.wdata = in_data;
      end
      ST_LD_RF: begin
        in_ready      = slot_free;
        slot_req      = slot_free && in_valid;
        slot_rq.addr  = A_RF;
        slot_rq.wdata = in_data;
      end
      ST_RD_DOUT: begin
        slot_req      = slot_free && !rd_pend;
        slot_rq.rw    = 1'b0;
        slot_rq.addr  = A_DOUT;
      end
      ST_CLR: begin
        slot_req      = slot_free;
        slot_rq.addr  = A_CTRL;
        slot_rq.wdata = ctrl_word(1'b0, 1'b0, AXIS_X);
      end
      default: ;
    endcase
  end

  // Batch sequencing, word/timeout counting and result reporting
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_IDLE;
      code_q      <= '0;
      axis        <= AXIS_X;
      wcnt        <= '0;
      tcnt        <= '0;
      rd_pend     <= 1'b0;
      busy        <= 1'b0;
      group_valid <= 1'b0;
      group       <= '0;
      timeout     <= 1'b0;
    end else begin
      group_valid <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            code_q <= feature_code;
            axis   <= AXIS_X;
            busy   <= 1'b1;
            state  <= ST_WR_FCL;
          end
        end
        ST_WR_FCL: begin
          if (slot_free) state <= ST_WR_FCH;
        end
        ST_WR_FCH: begin
          if (slot_free) state <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          if (slot_free) begin
            wcnt  <= '0;
            state <= ST_LD_CENT;
          end
        end
        ST_LD_CENT: begin
          if (accept) begin
            if (wcnt == CENT_LAST) begin
              wcnt  <= '0;
              state <= ST_LD_RF;
            end else begin
              wcnt <= wcnt + 16'd1;
            end
          end
        end
        ST_LD_RF: begin
          if (accept) begin
            if (wcnt == SAMP_LAST) begin
              wcnt <= '0;
              if (axis == AXIS_Z) begin
                tcnt  <= '0;
                state <= ST_WAIT_INT;
              end else begin
                axis  <= axis + 2'd1;
                state <= ST_WR_CTRL;
              end
            end else begin
              wcnt <= wcnt + 16'd1;
            end
          end
        end
        ST_WAIT_INT: begin
          // Interrupt takes priority over a coincident terminal count
          if (bus.intr) begin
            rd_pend <= 1'b0;
            state   <= ST_RD_DOUT;
          end else if (tcnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= ST_CLR;
          end else if (tcnt != 16'hFFFF) begin
            tcnt <= tcnt + 16'd1;
          end
        end
        ST_RD_DOUT: begin
          // Ignore the done of any write still draining; wait for our read
          if (!rd_pend) begin
            if (slot_free) rd_pend <= 1'b1;
          end else if (slot_done) begin
            group       <= slot_rd;
            group_valid <= 1'b1;
            rd_pend     <= 1'b0;
            state       <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (slot_free) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fs_bus_slot #(.RD_W(2)) u_slot (
    .clk      (clk),
    .nReset   (nReset),
    .req      (slot_req),
    .req_data (slot_rq),
    .rdata    (bus.rdata[1:0]),
    .free     (slot_free),
    .done     (slot_done),
    .rd_q     (slot_rd),
    .addr     (bus.addr),
    .wdata    (bus.wdata),
    .nCs      (bus.nCs),
    .nWr      (bus.nWr),
    .nRd      (bus.nRd)
  );

endmodule

// File: tb/tb_fs_host_sequencer.sv
// Directed bench for fs_host_sequencer with a small slave model, a stream
// feeder and a bus monitor logging every write.
module tb_fs_host_sequencer;

  logic        clk;
  logic        nReset;
  logic        go;
  logic [29:0] feature_code;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        group_valid;
  logic [1:0]  group;
  logic        timeout;
  logic [15:0] dout_val;

  fs_host_sequencer_if bus ();

  fs_host_sequencer #(
    .CENT_PER_AXIS    (10),
    .SAMPLES_PER_AXIS (4),
    .TIMEOUT          (100)
  ) dut (
    .clk          (clk),
    .nReset       (nReset),
    .go           (go),
    .feature_code (feature_code),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .bus          (bus.master),
    .busy         (busy),
    .group_valid  (group_valid),
    .group        (group),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: DOUT readable combinationally during the read strobe
  assign bus.rdata = (!bus.nCs && !bus.nRd && bus.addr == 3'd3) ? dout_val : 16'h0000;

  int checks = 0;
  int errors = 0;

  logic [18:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [18:0] exp_q[$];
  logic [15:0] stream_q[$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          gv_cnt = 0;
  int          to_cnt = 0;
  int          to_cyc = 0;
  int          hs_cnt = 0;
  logic [1:0]  gv_group = 2'b00;
  bit          toggle_mode = 1'b0;
  bit          tog = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream feeder: presents the head of stream_q, pops on handshake
  initial begin
    in_valid = 1'b0;
    in_data  = 16'h0000;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (stream_q.size() > 0 && (!toggle_mode || tog)) begin
        in_valid = 1'b1;
        in_data  = stream_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 16'h0000;
      end
      @(posedge clk);
      if (in_valid && in_ready && stream_q.size() > 0) begin
        void'(stream_q.pop_front());
        hs_cnt++;
      end
    end
  end

  // Bus / output monitor sampled at each rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (nReset) begin
        if (!bus.nCs && !bus.nWr) begin
          wr_q.push_back({bus.addr, bus.wdata});
          wr_cyc_q.push_back(cyc);
        end
        if (!bus.nCs && !bus.nRd) rd_cnt++;
        if (group_valid) begin
          gv_cnt++;
          gv_group = group;
        end
        if (timeout) begin
          to_cnt++;
          to_cyc = cyc;
        end
      end
    end
  end

  // Expected write list and stream contents for one batch
  task automatic load_batch(input logic [29:0] code, input logic [15:0] base);
    exp_q.delete();
    stream_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
    rd_cnt = 0; gv_cnt = 0; to_cnt = 0; hs_cnt = 0;
    exp_q.push_back({3'd6, code[15:0]});
    exp_q.push_back({3'd7, 2'b00, code[29:16]});
    for (int ax = 0; ax < 3; ax++) begin
      exp_q.push_back({3'd2, 16'h8004 | 16'(ax)});
      for (int i = 0; i < 10; i++) begin
        stream_q.push_back(16'hC000 + base + 16'(ax * 256 + i));
        exp_q.push_back({3'd1, 16'hC000 + base + 16'(ax * 256 + i)});
      end
      for (int j = 0; j < 4; j++) begin
        stream_q.push_back(16'h5000 + base + 16'(ax * 256 + j));
        exp_q.push_back({3'd0, 16'h5000 + base + 16'(ax * 256 + j)});
      end
    end
    exp_q.push_back({3'd2, 16'h0000});
  endtask

  task automatic pulse_go(input logic [29:0] code);
    @(negedge clk);
    feature_code = code;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k;
    k = 0;
    while (wr_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(wr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  task automatic finish_with_intr(input string tag);
    int k;
    wait_writes(47, {tag, "_reach_wait"});
    repeat (5) @(negedge clk);
    check({tag, "_no_read_before_intr"}, 32'(rd_cnt), 32'd0);
    check({tag, "_busy_in_wait"}, 32'(busy), 32'd1);
    bus.intr = 1'b1;
    k = 0;
    while (gv_cnt == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    bus.intr = 1'b0;
    check({tag, "_gv_seen"}, 32'(gv_cnt), 32'd1);
    wait_idle({tag, "_idle"});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d;
    nReset = 1'b0;
    go = 1'b0;
    feature_code = '0;
    dout_val = 16'h0000;
    bus.intr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_nCs", 32'(bus.nCs), 32'd1);
    check("rst_nWr", 32'(bus.nWr), 32'd1);
    check("rst_nRd", 32'(bus.nRd), 32'd1);
    check("rst_addr_wdata", {13'd0, bus.addr, bus.wdata}, 32'd0);
    check("rst_outs", {27'd0, in_ready, busy, group_valid, timeout, 1'b0}, 32'd0);
    check("rst_group", 32'(group), 32'd0);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Full batch, all-ones code, group 1; intr pulse during LD_CENT ignored
    toggle_mode = 1'b0;
    dout_val = 16'h0001;
    load_batch(30'h3FFFFFFF, 16'h0000);
    pulse_go(30'h3FFFFFFF);
    check("b1_busy", 32'(busy), 32'd1);
    wait_writes(5, "b1_reach_cent");
    bus.intr = 1'b1;
    repeat (3) @(negedge clk);
    bus.intr = 1'b0;
    check("b1_early_intr_no_read", 32'(rd_cnt), 32'd0);
    finish_with_intr("b1");
    check("b1_group", 32'(gv_group), 32'd1);
    check("b1_reads", 32'(rd_cnt), 32'd1);
    check("b1_no_timeout", 32'(to_cnt), 32'd0);
    compare_writes("b1");

    // Stalling stream, second go ignored, group 2
    toggle_mode = 1'b1;
    dout_val = 16'h0002;
    load_batch(30'h12345678, 16'h0020);
    pulse_go(30'h12345678);
    wait_writes(20, "b2_reach_y");
    pulse_go(30'h0ABCDEF0);
    finish_with_intr("b2");
    check("b2_group", 32'(gv_group), 32'd2);
    check("b2_handshakes", 32'(hs_cnt), 32'd42);
    compare_writes("b2");
    toggle_mode = 1'b0;

    // Interrupt never arrives: timeout after 100 cycles in WAIT_INT
    load_batch(30'h00000005, 16'h0040);
    pulse_go(30'h00000005);
    wait_idle("b3_idle");
    repeat (3) @(negedge clk);
    check("b3_timeout_pulses", 32'(to_cnt), 32'd1);
    d = (wr_cyc_q.size() > 46) ? (to_cyc - wr_cyc_q[46]) : -1;
    check("b3_timeout_delay", 32'(d), 32'd100);
    check("b3_no_gv", 32'(gv_cnt), 32'd0);
    check("b3_no_read", 32'(rd_cnt), 32'd0);
    compare_writes("b3");

    // Reset during LD_RF on axis y, then a clean restart from axis x
    load_batch(30'h2AAA5555, 16'h0060);
    pulse_go(30'h2AAA5555);
    wait_writes(29, "b4_reach_rf_y");
    nReset = 1'b0;
    #1;
    check("b4_rst_nCs", 32'(bus.nCs), 32'd1);
    check("b4_rst_busy", 32'(busy), 32'd0);
    check("b4_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    dout_val = 16'h0000;
    load_batch(30'h15555AAA, 16'h0080);
    pulse_go(30'h15555AAA);
    finish_with_intr("b4");
    check("b4_group", 32'(gv_group), 32'd0);
    compare_writes("b4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
